// File: rtl/pxl_write_arbiter_if.sv
// pxl_write_arbiter_if: requester-side and pixel-port signals of the write arbiter.
interface pxl_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_last_i;
    logic [NREQ*ADDR_W-1:0] req_addr_i;
    logic [NREQ*DATA_W-1:0] req_data_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [ADDR_W-1:0]      pxl_addr_o;
    logic [DATA_W-1:0]      pxl_data_o;
    logic                   pxl_en_o;
    logic [NREQ-1:0]        grant_o;
    logic                   busy_o;

    modport master (
        output req_valid_i, req_last_i, req_addr_i, req_data_i,
        input  req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, grant_o, busy_o
    );
    modport slave (
        input  req_valid_i, req_last_i, req_addr_i, req_data_i,
        output req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, grant_o, busy_o
    );
endinterface

// File: rtl/pxl_write_arbiter.sv
// pxl_write_arbiter: round-robin, burst-locked sharing of one pixel-write port among NREQ writers.
module pxl_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int MAX_BURST  = 16,
    parameter int BLANK_ONLY = 0
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          vblank_i,
    pxl_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              en_q, en_d;
    logic [PW-1:0]     pick, gidx, idx;
    logic              gate, hs, done;

    assign gate            = (BLANK_ONLY == 0) || vblank_i;
    assign bus.req_ready_o = gate ? grant_q : '0;
    assign hs              = |(bus.req_ready_o & bus.req_valid_i);
    assign done            = hs && ((|(grant_q & bus.req_last_i)) || cnt_q == CW'(MAX_BURST - 1));
    assign bus.pxl_addr_o  = addr_q;
    assign bus.pxl_data_o  = data_q;
    assign bus.pxl_en_o    = en_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = state_q == BURST;

    // Scan offsets downward so the valid index closest at/after the pointer wins.
    always_comb begin
        pick = '0;
        gidx = '0;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (bus.req_valid_i[idx]) pick = idx;
        end
        for (int i = 0; i < NREQ; i++)
            if (grant_q[i]) gidx = PW'(i);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        if (state_q == IDLE) begin
            if (gate && |bus.req_valid_i) begin
                state_d = BURST;
                grant_d = NREQ'(1) << pick;
                cnt_d   = '0;
            end
        end else if (hs) begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = bus.req_addr_i[gidx*ADDR_W +: ADDR_W];
            data_d = bus.req_data_i[gidx*DATA_W +: DATA_W];
            en_d   = 1'b1;
            if (done) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end
endmodule

// File: tb/tb_pxl_write_arbiter.sv
// tb_pxl_write_arbiter: two arbiter configurations driven by shared stimulus, checked against a queue-free behavioural model.
module tb_pxl_write_arbiter;
    localparam int N = 4, AW = 20, DW = 16;

    logic clk = 1'b0, rst, vblank;
    logic [N-1:0]    valid, last;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;

    pxl_write_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    pxl_write_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.req_valid_i = valid;
    assign ifa.req_last_i  = last;
    assign ifa.req_addr_i  = addr;
    assign ifa.req_data_i  = data;
    assign ifb.req_valid_i = valid;
    assign ifb.req_last_i  = last;
    assign ifb.req_addr_i  = addr;
    assign ifb.req_data_i  = data;

    pxl_write_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4), .BLANK_ONLY(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .vblank_i(vblank), .bus(ifa.slave));
    pxl_write_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .BLANK_ONLY(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .vblank_i(vblank), .bus(ifb.slave));

    always #5 clk = ~clk;

    logic [N-1:0]  g_s[2], r_s[2];
    logic          e_s[2], b_s[2];
    logic [AW-1:0] a_s[2];
    logic [DW-1:0] d_s[2];
    assign g_s[0] = ifa.grant_o;    assign g_s[1] = ifb.grant_o;
    assign r_s[0] = ifa.req_ready_o; assign r_s[1] = ifb.req_ready_o;
    assign e_s[0] = ifa.pxl_en_o;   assign e_s[1] = ifb.pxl_en_o;
    assign b_s[0] = ifa.busy_o;     assign b_s[1] = ifb.busy_o;
    assign a_s[0] = ifa.pxl_addr_o; assign a_s[1] = ifb.pxl_addr_o;
    assign d_s[0] = ifa.pxl_data_o; assign d_s[1] = ifb.pxl_data_o;

    int errors = 0, checks = 0;
    bit chk_on = 0, rec_on = 0;

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", name, m, $time, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: owner index (-1 when idle), pointer, handshakes in current burst, last write.
    int mb[2] = '{4, 16};
    int bo[2] = '{1, 0};
    int own[2] = '{-1, -1};
    int ptr[2], cnt[2];
    logic          m_en[2];
    logic [AW-1:0] m_a[2];
    logic [DW-1:0] m_d[2];
    bit mg;

    int npulse[2];
    int nseq[2];
    int seq[2][32], run[2][32];
    logic [N-1:0] prevg[2];

    // Inputs change only just after posedge, so the values seen here are the ones the next edge samples.
    initial forever begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            mg = (bo[m] == 0) || vblank;
            if (chk_on) begin
                check("grant", m, g_s[m], own[m] < 0 ? 0 : (32'd1 << own[m]));
                check("busy", m, b_s[m], own[m] >= 0);
                check("ready", m, r_s[m], (own[m] >= 0 && mg) ? (32'd1 << own[m]) : 0);
                check("pxl_en", m, e_s[m], m_en[m]);
                check("pxl_addr", m, a_s[m], m_a[m]);
                check("pxl_data", m, d_s[m], m_d[m]);
            end
            if (e_s[m] === 1'b1) npulse[m]++;
            if (rec_on && g_s[m] != 0) begin
                if (prevg[m] == 0 && nseq[m] < 32) begin
                    seq[m][nseq[m]] = onehot_idx(g_s[m]);
                    run[m][nseq[m]] = 0;
                    nseq[m]++;
                end
                if (nseq[m] > 0 && |(r_s[m] & valid)) run[m][nseq[m]-1]++;
            end
            prevg[m] = g_s[m];
            if (rst) begin
                own[m] = -1; ptr[m] = 0; cnt[m] = 0;
                m_en[m] = 1'b0; m_a[m] = '0; m_d[m] = '0;
            end else begin
                m_en[m] = 1'b0;
                if (own[m] < 0) begin
                    if (mg && valid != 0) begin
                        for (int o = N - 1; o >= 0; o--)
                            if (valid[(ptr[m] + o) % N]) own[m] = (ptr[m] + o) % N;
                        cnt[m] = 0;
                    end
                end else if (mg && valid[own[m]]) begin
                    m_en[m] = 1'b1;
                    m_a[m]  = addr[own[m]*AW +: AW];
                    m_d[m]  = data[own[m]*DW +: DW];
                    cnt[m]++;
                    if (last[own[m]] || cnt[m] == mb[m]) begin
                        ptr[m] = (own[m] + 1) % N;
                        own[m] = -1;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; valid = '0; last = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic rec_start;
        nseq[0] = 0; nseq[1] = 0;
        rec_on = 1;
    endtask

    int k, wc[N], p0, p1;
    bit hs;

    initial begin
        rst = 1'b1; vblank = 1'b1; valid = '0; last = '0; addr = '0; data = '0;
        do_reset;
        chk_on = 1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("rst_grant", m, g_s[m], 0);
            check("rst_en", m, e_s[m], 0);
        end
        tick;

        // Single requester, three-word burst.
        npulse[1] = 0; k = 0; valid = 4'b0010;
        for (int c = 0; c < 20 && k < 3; c++) begin
            addr[AW +: AW] = AW'(32'h100 + k);
            data[DW +: DW] = DW'(32'hA0A0 + k);
            last = (k == 2) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            hs = r_s[1][1];
            if (hs && k == 0) check("t1_grant", 1, g_s[1], 4'b0010);
            tick;
            if (hs) k++;
        end
        check("t1_words", 1, k, 3);
        valid = '0; last = '0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("t1_en", m, e_s[m], 1);
            check("t1_addr", m, a_s[m], 32'h102);
            check("t1_data", m, d_s[m], 32'hA0A2);
            check("t1_grant_end", m, g_s[m], 0);
            check("t1_busy_end", m, b_s[m], 0);
        end
        tick;
        check("t1_pulses", 1, npulse[1], 3);

        // Round-robin with 2-word bursts from all four requesters.
        do_reset;
        for (int i = 0; i < N; i++) wc[i] = 0;
        valid = 4'hF; npulse[1] = 0; rec_start;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) last[i] = (wc[i] % 2 == 1);
            @(negedge clk);
            hs = 1'b0;
            p1 = 0;
            for (int i = 0; i < N; i++) if (r_s[1][i] & valid[i]) p1 = i + 1;
            tick;
            if (p1 != 0) wc[p1-1]++;
            if (c == 5) p0 = npulse[1];
            if (c == 17) p1 = npulse[1] - p0;
            if (c == 17) check("t2_rate", 1, p1, 8);
        end
        rec_on = 0; valid = '0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++) check("t2_order", m, seq[m][i], i % 4);

        // Burst cap: req2 never presents last.
        do_reset;
        valid = 4'b1101; last = 4'b1001; rec_start;
        repeat (25) tick;
        rec_on = 0; valid = '0; last = '0;
        check("t3_order0", 0, seq[0][0], 0);
        check("t3_order1", 0, seq[0][1], 2);
        check("t3_order2", 0, seq[0][2], 3);
        check("t3_order3", 0, seq[0][3], 0);
        check("t3_order4", 0, seq[0][4], 2);
        check("t3_cap", 0, run[0][1], 4);
        check("t3_single", 0, run[0][0], 1);

        // Blanking gate on the BLANK_ONLY instance.
        do_reset;
        vblank = 1'b0; valid = 4'b0001; wc[0] = 0; npulse[0] = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t4_nogrant", 0, g_s[0], 0);
            tick;
        end
        check("t4_nowrite", 0, npulse[0], 0);
        vblank = 1'b1;
        tick;
        for (int c = 0; c < 20 && wc[0] < 2; c++) begin
            @(negedge clk);
            if (c == 0) check("t4_grant", 0, g_s[0], 4'b0001);
            hs = r_s[0][0] & valid[0];
            tick;
            if (hs) wc[0]++;
        end
        vblank = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_hold_rdy", 0, r_s[0], 0);
            check("t4_hold_gnt", 0, g_s[0], 4'b0001);
            tick;
        end
        vblank = 1'b1;
        for (int c = 0; c < 20 && wc[0] < 4; c++) begin
            last[0] = (wc[0] == 3);
            @(negedge clk);
            hs = r_s[0][0] & valid[0];
            tick;
            if (hs) wc[0]++;
        end
        valid = '0; last = '0;
        tick; tick;
        check("t4_pulses", 0, npulse[0], 4);
        check("t4_idle", 0, g_s[0], 0);

        // Reset mid-burst: req3 owns the port, pointer would otherwise favour it.
        addr[3*AW +: AW] = 20'h12345; data[3*DW +: DW] = 16'h5A5A;
        tick; tick;
        valid = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs = r_s[0][3];
            tick;
            if (hs) break;
        end
        rst = 1'b1; valid = 4'b1001;
        tick;
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("t5_grant", m, g_s[m], 0);
            check("t5_ready", m, r_s[m], 0);
            check("t5_en", m, e_s[m], 0);
            check("t5_addr", m, a_s[m], 0);
            check("t5_data", m, d_s[m], 0);
            check("t5_busy", m, b_s[m], 0);
        end
        tick;
        @(negedge clk);
        for (int m = 0; m < 2; m++) check("t5_regrant", m, g_s[m], 4'b0001);
        tick;

        // Valid gap: req1 owns the port and pauses while req0 waits.
        do_reset;
        valid = 4'b0010; last = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs = r_s[0][1];
            tick;
            if (hs) break;
        end
        valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                check("t6_hold", m, g_s[m], 4'b0010);
                if (c > 0) check("t6_nowrite", m, e_s[m], 0);
            end
            tick;
        end
        valid = 4'b0011; last = 4'b0010;
        @(negedge clk);
        check("t6_resume", 0, r_s[0], 4'b0010);
        tick;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("t6_en", m, e_s[m], 1);
            check("t6_release", m, g_s[m], 0);
        end
        tick;
        @(negedge clk);
        for (int m = 0; m < 2; m++) check("t6_next", m, g_s[m], 4'b0001);
        tick;

        // Random traffic, blanking and occasional resets.
        do_reset;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                valid[i] = ($urandom_range(9) < 7);
                last[i]  = ($urandom_range(9) < 3);
                addr[i*AW +: AW] = AW'($urandom());
                data[i*DW +: DW] = DW'($urandom());
            end
            vblank = ($urandom_range(3) != 0);
            rst    = ($urandom_range(199) == 0);
            tick;
        end
        rst = 1'b0; valid = '0;
        tick; tick; tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
